// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and data
// memory. Data has priority; a starvation counter forces a fetch grant after a run of data wins.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ack_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_ack_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and latch the winner
  // ISSUE | one-cycle memory strobe with latched address/we/wdata
  // WAIT  | count down the fixed memory latency, capture read data at zero
  // RESP  | one-cycle ack to the owner; requests not sampled
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] LATENCY4 = 4'(MEM_LATENCY);
  localparam logic [3:0] LIMIT4   = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  grant_dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_dm_q   <= owner_dm_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_dm_d   = owner_dm_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    grant_dm     = dm_req_i && !(if_req_i && (starve_cnt_q == LIMIT4));
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d    = ISSUE;
          owner_dm_d = grant_dm;
          if (grant_dm) begin
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            wdata_d = dm_wdata_i;
            if (if_req_i)
              starve_cnt_d = (starve_cnt_q == LIMIT4) ? starve_cnt_q : starve_cnt_q + 4'd1;
            else
              starve_cnt_d = '0;
          end else begin
            addr_d       = if_addr_i;
            we_d         = 1'b0;
            starve_cnt_d = '0;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = LATENCY4;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        // Counter hits zero this cycle: mem_rdata is valid now.
        if (wait_cnt_q == 4'd1) begin
          state_d = RESP;
          if (!owner_dm_q)
            if_rdata_d = mem_rdata_i;
          else if (!we_q)
            dm_rdata_d = mem_rdata_i;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = (state_q == ISSUE) && owner_dm_q && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == RESP) && !owner_dm_q;
  assign dm_ack_o    = (state_q == RESP) && owner_dm_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_o     = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default instance plus MEM_LATENCY=1 and =5 instances,
// each fed by a fixed-latency memory model that only presents data in the valid cycle.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_req_s;
  logic [AW-1:0] if_addr_s;

  logic [DW-1:0] if_rdata [3];
  logic [DW-1:0] dm_rdata [3];
  logic [DW-1:0] m_wdata  [3];
  logic [DW-1:0] m_rdata  [3];
  logic [AW-1:0] m_addr   [3];
  logic          if_ack [3];
  logic          dm_ack [3];
  logic          m_en   [3];
  logic          m_we   [3];
  logic          stall  [3];

  logic [DW-1:0] mem [1<<AW];

  mem_port_arbiter dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata[0]), .if_ack_o(if_ack[0]),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata[0]), .dm_ack_o(dm_ack[0]),
    .mem_en_o(m_en[0]), .mem_we_o(m_we[0]), .mem_addr_o(m_addr[0]), .mem_wdata_o(m_wdata[0]),
    .mem_rdata_i(m_rdata[0]), .stall_o(stall[0]));

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_s), .if_addr_i(if_addr_s), .if_rdata_o(if_rdata[1]), .if_ack_o(if_ack[1]),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i('0), .dm_wdata_i('0),
    .dm_rdata_o(dm_rdata[1]), .dm_ack_o(dm_ack[1]),
    .mem_en_o(m_en[1]), .mem_we_o(m_we[1]), .mem_addr_o(m_addr[1]), .mem_wdata_o(m_wdata[1]),
    .mem_rdata_i(m_rdata[1]), .stall_o(stall[1]));

  mem_port_arbiter #(.MEM_LATENCY(5)) dut2 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_s), .if_addr_i(if_addr_s), .if_rdata_o(if_rdata[2]), .if_ack_o(if_ack[2]),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i('0), .dm_wdata_i('0),
    .dm_rdata_o(dm_rdata[2]), .dm_ack_o(dm_ack[2]),
    .mem_en_o(m_en[2]), .mem_we_o(m_we[2]), .mem_addr_o(m_addr[2]), .mem_wdata_o(m_wdata[2]),
    .mem_rdata_i(m_rdata[2]), .stall_o(stall[2]));

  // Preload during reset; only the default instance ever writes.
  always @(posedge clk) begin
    if (rst) begin
      mem[5] <= 32'h8C22_0004;
      mem[7] <= 32'h1234_5678;
    end else if (m_en[0] && m_we[0]) begin
      mem[m_addr[0]] <= m_wdata[0];
    end
  end

  // Poison value outside the valid cycle catches off-by-one sampling.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic [DW-1:0] d [L];
    logic          v [L];
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < L; i++) v[i] <= 1'b0;
      end else begin
        v[0] <= m_en[g] && !m_we[g];
        for (int i = 1; i < L; i++) v[i] <= v[i-1];
      end
      d[0] <= mem[m_addr[g]];
      for (int i = 1; i < L; i++) d[i] <= d[i-1];
    end
    assign m_rdata[g] = v[L-1] ? d[L-1] : 32'hBAD0_BAD0;
  end

  int   en_cnt = 0;
  bit   ack_log[$];
  always @(posedge clk) begin
    if (m_en[0]) en_cnt <= en_cnt + 1;
    if (dm_ack[0]) ack_log.push_back(1'b1);
    else if (if_ack[0]) ack_log.push_back(1'b0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          en_before;
  int          lat1, lat5;
  logic [5:0]  exp_seq;

  initial begin
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req_s = 0; if_addr_s = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", m_en[0], 0);
    chk("rst_mem_we", m_we[0], 0);
    chk("rst_mem_addr", m_addr[0], 0);
    chk("rst_mem_wdata", m_wdata[0], 0);
    chk("rst_if_ack", if_ack[0], 0);
    chk("rst_dm_ack", dm_ack[0], 0);
    chk("rst_if_rdata", if_rdata[0], 0);
    chk("rst_dm_rdata", dm_rdata[0], 0);
    chk("rst_stall", stall[0], 0);
    chk("rst_starve", dut0.starve_cnt_q, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    // single fetch
    @(negedge clk); if_req = 1; if_addr = 10'd5; #1;
    chk("t1_stall_R", stall[0], 1);
    chk("t1_en_R", m_en[0], 0);
    @(negedge clk); #1;
    chk("t1_en_R1", m_en[0], 1);
    chk("t1_addr_R1", m_addr[0], 5);
    chk("t1_we_R1", m_we[0], 0);
    chk("t1_stall_R1", stall[0], 1);
    @(negedge clk); #1;
    chk("t1_en_R2", m_en[0], 0);
    chk("t1_stall_R2", stall[0], 1);
    @(negedge clk); #1;
    chk("t1_ack_R3", if_ack[0], 0);
    chk("t1_stall_R3", stall[0], 1);
    @(negedge clk); #1;
    chk("t1_ack_R4", if_ack[0], 1);
    chk("t1_rdata_R4", if_rdata[0], 32'h8C22_0004);
    chk("t1_dmack_R4", dm_ack[0], 0);
    chk("t1_stall_R4", stall[0], 0);
    @(negedge clk); if_req = 0; #1;
    chk("t1_ack_R5", if_ack[0], 0);

    // data write then read of the same word
    @(negedge clk); dm_req = 1; dm_we = 1; dm_addr = 10'd12; dm_wdata = 32'hDEAD_BEEF; #1;
    @(negedge clk); #1;
    chk("t2_en_R1", m_en[0], 1);
    chk("t2_we_R1", m_we[0], 1);
    chk("t2_addr_R1", m_addr[0], 12);
    chk("t2_wdata_R1", m_wdata[0], 32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("t2_we_R2", m_we[0], 0);
    chk("t2_en_R2", m_en[0], 0);
    @(negedge clk); #1;
    chk("t2_we_R3", m_we[0], 0);
    @(negedge clk); #1;
    chk("t2_wack_R4", dm_ack[0], 1);
    chk("t2_wrdata_R4", dm_rdata[0], 0);
    chk("t2_ifack_R4", if_ack[0], 0);
    @(negedge clk); dm_we = 0; #1;
    chk("t2_ack_R5", dm_ack[0], 0);
    @(negedge clk); #1;
    chk("t2_ren_R6", m_en[0], 1);
    chk("t2_rwe_R6", m_we[0], 0);
    chk("t2_raddr_R6", m_addr[0], 12);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_rack_R9", dm_ack[0], 1);
    chk("t2_rdata_R9", dm_rdata[0], 32'hDEAD_BEEF);
    @(negedge clk); dm_req = 0;

    // simultaneous requests: data first, fetch at the following IDLE
    en_before = en_cnt;
    @(negedge clk); if_req = 1; if_addr = 10'd7; dm_req = 1; dm_we = 0; dm_addr = 10'd12; #1;
    @(negedge clk); #1;
    chk("t3_en_R1", m_en[0], 1);
    chk("t3_addr_R1", m_addr[0], 12);
    repeat (3) @(negedge clk);
    #1;
    chk("t3_dmack_R4", dm_ack[0], 1);
    chk("t3_ifack_R4", if_ack[0], 0);
    chk("t3_stall_R4", stall[0], 1);
    @(negedge clk); dm_req = 0; #1;
    chk("t3_dmack_R5", dm_ack[0], 0);
    @(negedge clk); #1;
    chk("t3_en_R6", m_en[0], 1);
    chk("t3_addr_R6", m_addr[0], 7);
    repeat (3) @(negedge clk);
    #1;
    chk("t3_ifack_R9", if_ack[0], 1);
    chk("t3_rdata_R9", if_rdata[0], 32'h1234_5678);
    @(negedge clk); if_req = 0; #1;
    chk("t3_en_count", en_cnt - en_before, 2);

    // starvation: both held, expect D D D D I D
    ack_log.delete();
    @(negedge clk); if_req = 1; if_addr = 10'd5; dm_req = 1; dm_we = 0; dm_addr = 10'd12;
    for (int c = 0; c < 80 && ack_log.size() < 6; c++) begin
      @(negedge clk); #1;
      if (dm_ack[0] && ack_log.size() == 3) chk("t4_starve_sat", dut0.starve_cnt_q, 4);
      if (if_ack[0]) chk("t4_starve_after_if", dut0.starve_cnt_q, 0);
    end
    if_req = 0; dm_req = 0;
    chk("t4_ack_count", ack_log.size(), 6);
    exp_seq = 6'b101111;
    for (int i = 0; i < 6; i++) chk($sformatf("t4_grant%0d", i), ack_log[i], exp_seq[i]);

    // latency sweep on the MEM_LATENCY=1 and =5 instances
    lat1 = -1; lat5 = -1;
    @(negedge clk); if_req_s = 1; if_addr_s = 10'd7;
    @(negedge clk); #1;
    chk("t5_en_lat1", m_en[1], 1);
    chk("t5_en_lat5", m_en[2], 1);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk); #1;
      if (if_ack[1] && lat1 < 0) begin
        lat1 = c;
        chk("t5_rdata_lat1", if_rdata[1], 32'h1234_5678);
      end
      if (if_ack[2] && lat5 < 0) begin
        lat5 = c;
        chk("t5_rdata_lat5", if_rdata[2], 32'h1234_5678);
      end
    end
    @(negedge clk); if_req_s = 0;
    chk("t5_ack_time_lat1", lat1, 3);
    chk("t5_ack_time_lat5", lat5, 7);

    // reset during WAIT abandons the transaction
    @(negedge clk); if_req = 1; if_addr = 10'd5;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_en_R2", m_en[0], 0);
    rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("t6_state_idle", dut0.state_q, 0);
    chk("t6_ifack", if_ack[0], 0);
    chk("t6_dmack", dm_ack[0], 0);
    chk("t6_en", m_en[0], 0);
    chk("t6_we", m_we[0], 0);
    chk("t6_addr", m_addr[0], 0);
    chk("t6_wdata", m_wdata[0], 0);
    chk("t6_if_rdata", if_rdata[0], 0);
    chk("t6_dm_rdata", dm_rdata[0], 0);
    @(negedge clk); #1;
    chk("t6_restart_en", m_en[0], 1);
    chk("t6_restart_addr", m_addr[0], 5);
    chk("t6_noack_R4", if_ack[0], 0);
    @(negedge clk); #1;
    chk("t6_noack_R5", if_ack[0], 0);
    @(negedge clk); #1;
    chk("t6_noack_R6", if_ack[0], 0);
    @(negedge clk); #1;
    chk("t6_ack_R7", if_ack[0], 1);
    chk("t6_rdata_R7", if_rdata[0], 32'h8C22_0004);
    @(negedge clk); if_req = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
